// File: rtl/word_serializer.sv
// Parallel-to-serial front end: takes words over valid/ready and shifts them out
// one bit at a time, each bit held BIT_PERIOD clocks, with back-to-back support and abort.
module word_serializer #(
   parameter int unsigned WORD_BITS  = 8,
   parameter int unsigned MSB_FIRST  = 1,
   parameter int unsigned BIT_PERIOD = 1,
   parameter logic        IDLE_BIT   = 1'b0
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [WORD_BITS-1:0] data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   input  logic                 clear,
   output logic                 serial_out,
   output logic                 serial_active,
   output logic                 word_done
);

   localparam int unsigned IDX_W  = $clog2(WORD_BITS);
   localparam int unsigned TICK_W = $clog2(BIT_PERIOD) + 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BITS - 1);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(BIT_PERIOD - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t               state_r, state_s;
   logic [WORD_BITS-1:0] shift_r, shift_s, shifted_s;
   logic [IDX_W-1:0]     bit_idx_r, bit_idx_s;
   logic [TICK_W-1:0]    tick_r, tick_s;
   logic                 serial_out_r, serial_out_s;
   logic                 active_r, active_s;
   logic                 done_r, done_s;
   logic                 last_s, accept_s;

   // Bit currently at the output end of a word image.
   function automatic logic out_end(input logic [WORD_BITS-1:0] w);
      if (MSB_FIRST != 32'd0) begin
         return w[WORD_BITS-1];
      end else begin
         return w[0];
      end
   endfunction

   // Handshake and end-of-word decode.
   always_comb begin
      last_s     = (state_r == SHIFT) && (bit_idx_r == LAST_IDX) && (tick_r == LAST_TICK);
      data_ready = (state_r == IDLE) || last_s;
      accept_s   = data_valid && data_ready && !clear;
   end

   // Shift toward the output end; the vacated bit is don't-care.
   always_comb begin
      if (MSB_FIRST != 32'd0) begin
         shifted_s = {shift_r[WORD_BITS-2:0], 1'b0};
      end else begin
         shifted_s = {1'b0, shift_r[WORD_BITS-1:1]};
      end
   end

   // Next-state and next-output logic; clear outranks accept and end of word.
   always_comb begin
      state_s      = state_r;
      shift_s      = shift_r;
      bit_idx_s    = bit_idx_r;
      tick_s       = tick_r;
      serial_out_s = serial_out_r;
      active_s     = active_r;
      done_s       = 1'b0;
      if (clear) begin
         state_s      = IDLE;
         bit_idx_s    = '0;
         tick_s       = '0;
         serial_out_s = IDLE_BIT;
         active_s     = 1'b0;
      end else if (accept_s) begin
         state_s      = SHIFT;
         shift_s      = data_in;
         bit_idx_s    = '0;
         tick_s       = '0;
         serial_out_s = out_end(data_in);
         active_s     = 1'b1;
         done_s       = last_s;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            SHIFT: begin
               if (last_s) begin
                  state_s      = IDLE;
                  bit_idx_s    = '0;
                  tick_s       = '0;
                  serial_out_s = IDLE_BIT;
                  active_s     = 1'b0;
                  done_s       = 1'b1;
               end else if (tick_r == LAST_TICK) begin
                  tick_s       = '0;
                  bit_idx_s    = bit_idx_r + IDX_W'(1);
                  shift_s      = shifted_s;
                  serial_out_s = out_end(shifted_s);
               end else begin
                  tick_s = tick_r + TICK_W'(1);
               end
            end
            default: begin
               state_s      = IDLE;
               serial_out_s = IDLE_BIT;
               active_s     = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r      <= IDLE;
         shift_r      <= '0;
         bit_idx_r    <= '0;
         tick_r       <= '0;
         serial_out_r <= IDLE_BIT;
         active_r     <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         shift_r      <= shift_s;
         bit_idx_r    <= bit_idx_s;
         tick_r       <= tick_s;
         serial_out_r <= serial_out_s;
         active_r     <= active_s;
         done_r       <= done_s;
      end
   end

   assign serial_out    = serial_out_r;
   assign serial_active = active_r;
   assign word_done     = done_r;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: a default (P=1, MSB first) instance and a
// P=3, LSB-first instance; expected bits are queued at accept and popped per cycle.
module tb_word_serializer;

   logic       clk;
   logic       n_rst;
   logic [7:0] data_in;
   logic       data_valid, clear;
   logic       data_ready, serial_out, serial_active, word_done;
   logic [7:0] d3_data;
   logic       d3_valid, d3_clear;
   logic       d3_ready, d3_sout, d3_active, d3_done;

   int  pass_cnt = 0;
   int  chk_cnt  = 0;
   bit  q_bits[$];
   bit  q_bits3[$];

   word_serializer dut (
      .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .clear(clear), .serial_out(serial_out),
      .serial_active(serial_active), .word_done(word_done)
   );

   word_serializer #(.WORD_BITS(8), .MSB_FIRST(0), .BIT_PERIOD(3), .IDLE_BIT(1'b0)) dut3 (
      .clk(clk), .n_rst(n_rst), .data_in(d3_data), .data_valid(d3_valid),
      .data_ready(d3_ready), .clear(d3_clear), .serial_out(d3_sout),
      .serial_active(d3_active), .word_done(d3_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      n_rst = 1'b1; data_in = 8'h00; data_valid = 1'b0; clear = 1'b0;
      d3_data = 8'h00; d3_valid = 1'b0; d3_clear = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      chk_cnt++;
      if ({serial_out, serial_active, word_done, data_ready} !== 4'b0001) begin
         $display("FAIL reset_outputs: got %b expected 0001", {serial_out, serial_active, word_done, data_ready});
      end else pass_cnt++;
      chk_cnt++;
      if ({d3_sout, d3_active, d3_done, d3_ready} !== 4'b0001) begin
         $display("FAIL reset_outputs_p3: got %b expected 0001", {d3_sout, d3_active, d3_done, d3_ready});
      end else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   // Sends one word on the default instance and checks every bit and the done pulse.
   task automatic run_word(input string name, input logic [7:0] w);
      bit exp;
      @(negedge clk);
      data_in = w; data_valid = 1'b1;
      chk_cnt++;
      if (data_ready !== 1'b1) $display("FAIL %s_ready_accept: got %b expected 1", name, data_ready);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) q_bits.push_back(w[7-i]);
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         if (j == 1) begin
            data_valid = 1'b0; data_in = ~w;
         end
         exp = (q_bits.size() > 0) ? q_bits.pop_front() : 1'bx;
         chk_cnt++;
         if ({serial_out, serial_active, word_done} !== {exp, 1'b1, 1'b0}) begin
            $display("FAIL %s_bit%0d: got out/act/done %b expected %b", name, j - 1,
                     {serial_out, serial_active, word_done}, {exp, 1'b1, 1'b0});
         end else pass_cnt++;
         chk_cnt++;
         if (data_ready !== (j == 8)) $display("FAIL %s_ready_c%0d: got %b expected %b", name, j, data_ready, (j == 8));
         else pass_cnt++;
      end
      @(negedge clk);
      chk_cnt++;
      if ({serial_out, serial_active, word_done, data_ready} !== 4'b0011) begin
         $display("FAIL %s_done: got out/act/done/ready %b expected 0011", name, {serial_out, serial_active, word_done, data_ready});
      end else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({serial_out, serial_active, word_done} !== 3'b000) begin
         $display("FAIL %s_after_done: got %b expected 000", name, {serial_out, serial_active, word_done});
      end else pass_cnt++;
   endtask

   task automatic test_single_word();
      run_word("d0", 8'hD0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] w0, w1;
      bit exp;
      w0 = 8'hDD; w1 = 8'hB5;
      @(negedge clk);
      data_in = w0; data_valid = 1'b1;
      chk_cnt++;
      if (data_ready !== 1'b1) $display("FAIL b2b_ready_k: got %b expected 1", data_ready);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) q_bits.push_back(w0[7-i]);
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         if (j == 1) data_in = w1;
         if (j == 8) for (int i = 0; i < 8; i++) q_bits.push_back(w1[7-i]);
         if (j == 9) data_valid = 1'b0;
         exp = (q_bits.size() > 0) ? q_bits.pop_front() : 1'bx;
         chk_cnt++;
         if ({serial_out, serial_active, word_done, data_ready} !== {exp, 1'b1, (j == 9), (j == 8 || j == 16)}) begin
            $display("FAIL b2b_c%0d: got out/act/done/ready %b expected %b", j,
                     {serial_out, serial_active, word_done, data_ready}, {exp, 1'b1, (j == 9), (j == 8 || j == 16)});
         end else pass_cnt++;
      end
      @(negedge clk);
      chk_cnt++;
      if ({serial_out, serial_active, word_done} !== 3'b001) begin
         $display("FAIL b2b_done2: got %b expected 001", {serial_out, serial_active, word_done});
      end else pass_cnt++;
   endtask

   task automatic test_stretch_lsb();
      logic [7:0] w;
      bit exp;
      w = 8'h0B;
      @(negedge clk);
      d3_data = w; d3_valid = 1'b1;
      chk_cnt++;
      if (d3_ready !== 1'b1) $display("FAIL p3_ready_accept: got %b expected 1", d3_ready);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) repeat (3) q_bits3.push_back(w[i]);
      for (int j = 1; j <= 24; j++) begin
         @(negedge clk);
         if (j == 1) begin
            d3_valid = 1'b0; d3_data = 8'hFF;
         end
         exp = (q_bits3.size() > 0) ? q_bits3.pop_front() : 1'bx;
         chk_cnt++;
         if ({d3_sout, d3_active, d3_done, d3_ready} !== {exp, 1'b1, 1'b0, (j == 24)}) begin
            $display("FAIL p3_c%0d: got out/act/done/ready %b expected %b", j,
                     {d3_sout, d3_active, d3_done, d3_ready}, {exp, 1'b1, 1'b0, (j == 24)});
         end else pass_cnt++;
      end
      @(negedge clk);
      chk_cnt++;
      if ({d3_sout, d3_active, d3_done} !== 3'b001) begin
         $display("FAIL p3_done: got %b expected 001", {d3_sout, d3_active, d3_done});
      end else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (d3_done !== 1'b0) $display("FAIL p3_done_pulse: got %b expected 0", d3_done);
      else pass_cnt++;
   endtask

   task automatic test_clear();
      @(negedge clk);
      data_in = 8'hFF; data_valid = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         if (j == 1) data_valid = 1'b0;
         chk_cnt++;
         if ({serial_out, serial_active} !== 2'b11) $display("FAIL clr_bit%0d: got %b expected 11", j - 1, {serial_out, serial_active});
         else pass_cnt++;
      end
      clear = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
      @(negedge clk);
      clear = 1'b0; data_valid = 1'b0;
      chk_cnt++;
      if ({serial_out, serial_active, word_done, data_ready} !== 4'b0001) begin
         $display("FAIL clr_abort: got out/act/done/ready %b expected 0001", {serial_out, serial_active, word_done, data_ready});
      end else pass_cnt++;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk_cnt++;
         if ({serial_active, word_done} !== 2'b00) $display("FAIL clr_quiet%0d: got %b expected 00", j, {serial_active, word_done});
         else pass_cnt++;
      end
      clear = 1'b1; data_valid = 1'b1; data_in = 8'hFF;
      @(negedge clk);
      clear = 1'b0; data_valid = 1'b0;
      chk_cnt++;
      if ({serial_out, serial_active} !== 2'b00) $display("FAIL clr_blocks_accept: got %b expected 00", {serial_out, serial_active});
      else pass_cnt++;
      run_word("restart", 8'h81);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      data_in = 8'hFF; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk_cnt++;
      if ({serial_out, serial_active, word_done, data_ready} !== 4'b0001) begin
         $display("FAIL rst_async: got out/act/done/ready %b expected 0001", {serial_out, serial_active, word_done, data_ready});
      end else pass_cnt++;
      @(negedge clk);
      n_rst = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         chk_cnt++;
         if ({serial_out, serial_active, word_done, data_ready} !== 4'b0001) begin
            $display("FAIL rst_after%0d: got %b expected 0001", j, {serial_out, serial_active, word_done, data_ready});
         end else pass_cnt++;
      end
   endtask

   task automatic test_idle();
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         chk_cnt++;
         if ({serial_out, serial_active, word_done, d3_sout, d3_done} !== 5'b00000) begin
            $display("FAIL idle_c%0d: got %b expected 00000", j, {serial_out, serial_active, word_done, d3_sout, d3_done});
         end else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stretch_lsb();
      test_clear();
      test_async_reset();
      test_idle();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
